mux_pipe_stage: RTL and testbench
=================================

Name: mux_pipe_stage

Overview:
Parametrised N-way source-select mux followed by a registered pipeline stage with valid/ready handshake and a 2-entry skid buffer.
- Generalises the team's 2:1 combinational mux to NUM_IN inputs and adds storage, backpressure and flush.
- Used between superscalar pipeline stages, e.g. operand-source select feeding the issue/execute boundary, where the downstream stage may stall.

Parameters:
WIDTH, 32, data width per input and of the output
NUM_IN, 4, number of selectable inputs (>=2)
SEL_W, $clog2(NUM_IN), width of select; derived, not to be overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_data  input  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH]
in_sel  input  SEL_W  source select, sampled with in_data
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat this cycle
flush  input  1  synchronous pipeline flush
out_data  output  WIDTH  registered selected data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts this cycle
occupancy  output  2  beats held (0..2)
sel_err  output  1  sticky out-of-range select flag (see Optional Feature)

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high, and named reset. No async paths.
- Fire rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Selection:
  - The muxed value is in_data[in_sel], computed combinationally and captured only on in_fire.
  - Out-of-range in_sel (NUM_IN not a power of 2) selects input 0.
- Storage and outputs:
  - Storage is a main register and a skid register, each with a valid bit.
  - out_data = main data; out_valid = main valid.
  - in_ready = !skid_valid. It is a pure register decode with no combinational path from out_ready.
- Latency: beat accepted in cycle N appears on out_data/out_valid in cycle N+1 at the earliest. There is no combinational pass-through.
- States (occupancy):
  - EMPTY (0):
    - in_fire -> main <= mux, ONE.
  - ONE (1):
    - in_fire & out_fire -> main <= mux, stay ONE.
    - out_fire only -> EMPTY.
    - in_fire only -> skid <= mux, FULL.
    - neither -> hold.
  - FULL (2): in_ready=0.
    - out_fire -> main <= skid, skid invalid, ONE.
    - else hold.
- Ordering: beats leave strictly in acceptance order. No loss or duplication under any out_ready pattern.
- Stability: while out_valid=1 and out_ready=0, out_data is held stable.
- Flush:
  - Priority over all handshakes.
  - Next cycle: occupancy=0, out_valid=0, in_ready=1.
  - A beat presented on the flush cycle is dropped, even if in_valid=1.
  - A pending out_fire in that cycle is still considered consumed downstream.
- Reset:
  - Same effect as flush. Additionally main/skid data <= 0 and sel_err <= 0.
  - Reset asserted mid-transfer discards all held beats.
  - reset has priority over flush.
- Reset values: out_data=0, out_valid=0, in_ready=1, occupancy=0, sel_err=0.

Optional Feature:
Macro MUX_PIPE_SEL_CHECK_EN.
- Defined:
  - sel_err sets on any in_fire with in_sel >= NUM_IN.
  - It stays set until reset; flush does not clear it.
  - The beat is still accepted with input 0 data.
- Undefined:
  - No range check logic.
  - sel_err tied to 0.
  - Data path unchanged.

Test Plan:
- Reset, then NUM_IN=4, WIDTH=32, in_data = {D3=0x33,D2=0x22,D1=0x11,D0=0x00}, in_sel=2, in_valid=1 for one cycle, out_ready=1 -> next cycle out_data=0x22, out_valid=1. Cycle after: out_valid=0, occupancy=0.
- Backpressure: out_ready=0, push sel=1 then sel=3 on consecutive cycles. Required: occupancy 1 then 2, in_ready=0 after the second beat, out_data=0x11 held. Raise out_ready -> 0x11 then 0x33 on consecutive cycles; in_ready returns 1 after the first drain.
- Streaming: in_valid=1 and out_ready=1 every cycle, sel cycling 0,1,2,3 -> output 0x00,0x11,0x22,0x33 back-to-back from cycle 1. Occupancy stays 1, in_ready never drops.
- Flush in FULL with in_valid=1 (sel=0) on the flush cycle -> next cycle occupancy=0, out_valid=0, in_ready=1. The flushed beat never appears on the output.
- Reset mid-operation: FULL state, assert reset one cycle -> all outputs equal their reset values next cycle, even with flush=1 and in_valid=1 simultaneously.
- NUM_IN=3 with MUX_PIPE_SEL_CHECK_EN defined: push sel=3 -> out_data=D0, sel_err=1. sel_err survives a flush and clears on reset. With the macro undefined, the same stimulus gives sel_err=0 and out_data=D0.

Source files
------------

// File: rtl/mux_pipe_stage.sv
// rtl/mux_pipe_stage.sv - NUM_IN:1 source-select mux into a registered valid/ready stage with 2-entry skid
// Optional range check on in_sel enabled by defining MUX_PIPE_SEL_CHECK_EN.
module mux_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              occupancy,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_mux;
  logic             w_in_fire;
  logic             w_out_fire;

  // Unmatched (out-of-range) selects fall through to input 0.
  always_comb begin
    w_mux = in_data[WIDTH-1:0];
    for (int i = 1; i < NUM_IN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        w_mux = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready   = (r_state != FULL);
  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;
  assign occupancy  = r_state;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main  <= w_mux;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= w_mux;
          end else if (w_out_fire) begin
            r_state <= EMPTY;
          end else if (w_in_fire) begin
            r_skid  <= w_mux;
            r_state <= FULL;
          end
        end
        FULL: begin
          // Skid drains into main so the older beat always leaves first.
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

`ifdef MUX_PIPE_SEL_CHECK_EN
  logic r_sel_err;
  logic w_sel_oob;

  assign w_sel_oob = (32'(in_sel) >= NUM_IN);

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_in_fire && w_sel_oob) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_stage.sv
// tb/tb_mux_pipe_stage.sv - scoreboard bench for mux_pipe_stage (NUM_IN=4 and NUM_IN=3 instances)
module tb_mux_pipe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   occupancy;
  logic         sel_err;

  logic [95:0]  d3_data;
  logic [1:0]   d3_sel;
  logic         d3_valid;
  logic         d3_in_ready;
  logic         d3_flush;
  logic [31:0]  d3_out_data;
  logic         d3_out_valid;
  logic         d3_out_ready;
  logic [1:0]   d3_occ;
  logic         d3_sel_err;

  int           n_checks = 0;
  int           n_pass = 0;
  int           n_fail = 0;
  logic [31:0]  q[$];
  logic         exp_err;

  always #5 clk = ~clk;

  mux_pipe_stage #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .sel_err(sel_err)
  );

  mux_pipe_stage #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(d3_data), .in_sel(d3_sel),
    .in_valid(d3_valid), .in_ready(d3_in_ready), .flush(d3_flush),
    .out_data(d3_out_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .occupancy(d3_occ), .sel_err(d3_sel_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mux4(input logic [127:0] d, input logic [1:0] s);
    return d[s*32 +: 32];
  endfunction

  // Compare dut4 against the reference FIFO, then advance one clock.
  task automatic cycle();
    int   occ;
    logic in_f;
    logic out_f;
    occ = q.size();
    check("occupancy", 64'(occupancy), 64'(occ));
    check("out_valid", 64'(out_valid), 64'(occ > 0));
    check("in_ready", 64'(in_ready), 64'(occ < 2));
    check("sel_err4", 64'(sel_err), 64'd0);
    if (occ > 0) check("out_data", 64'(out_data), 64'(q[0]));
    in_f  = in_valid && (occ < 2);
    out_f = (occ > 0) && out_ready;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(mux4(in_data, in_sel));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef MUX_PIPE_SEL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sel = 2'd0;
    in_data = {32'h33, 32'h22, 32'h11, 32'h00};
    d3_data = {32'hA2, 32'hA1, 32'hA0}; d3_sel = 2'd0; d3_valid = 1'b0;
    d3_flush = 1'b0; d3_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_sel_err3", 64'(d3_sel_err), 64'd0);
    reset = 1'b0;

    // Single beat, sel=2
    in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("t1_data", 64'(out_data), 64'h22);
    check("t1_valid", 64'(out_valid), 64'd1);
    cycle();
    check("t1_valid_after", 64'(out_valid), 64'd0);
    check("t1_occ_after", 64'(occupancy), 64'd0);

    // Backpressure into FULL, then drain
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    cycle();
    check("t2_occ1", 64'(occupancy), 64'd1);
    in_sel = 2'd3;
    cycle();
    in_valid = 1'b0;
    check("t2_occ2", 64'(occupancy), 64'd2);
    check("t2_in_ready", 64'(in_ready), 64'd0);
    check("t2_held", 64'(out_data), 64'h11);
    cycle();
    check("t2_still_held", 64'(out_data), 64'h11);
    out_ready = 1'b1;
    cycle();
    check("t2_second", 64'(out_data), 64'h33);
    check("t2_ready_back", 64'(in_ready), 64'd1);
    cycle();
    check("t2_drained", 64'(out_valid), 64'd0);

    // Streaming, sel cycling 0..3
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel = 2'(i % 4);
      cycle();
      check("t3_data", 64'(out_data), 64'(32'h11 * (i % 4)));
      check("t3_occ", 64'(occupancy), 64'd1);
      check("t3_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    cycle();

    // Flush in FULL with a beat presented
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    cycle();
    in_sel = 2'd2;
    cycle();
    flush = 1'b1; in_sel = 2'd0;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_occ", 64'(occupancy), 64'd0);
    check("t4_valid", 64'(out_valid), 64'd0);
    check("t4_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Reset in FULL alongside flush and in_valid
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd3;
    cycle();
    in_sel = 2'd1;
    cycle();
    reset = 1'b1; flush = 1'b1;
    cycle();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("t5_data", 64'(out_data), 64'd0);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_ready", 64'(in_ready), 64'd1);
    check("t5_occ", 64'(occupancy), 64'd0);

    // Random traffic against the reference FIFO
    for (int i = 0; i < 300; i++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // NUM_IN=3: out-of-range select
    d3_valid = 1'b1; d3_sel = 2'd3;
    cycle();
    d3_valid = 1'b0;
    check("t6_data", 64'(d3_out_data), 64'hA0);
    check("t6_valid", 64'(d3_out_valid), 64'd1);
    check("t6_sel_err", 64'(d3_sel_err), 64'(exp_err));
    d3_valid = 1'b1; d3_sel = 2'd2;
    cycle();
    d3_valid = 1'b0;
    check("t6_inrange", 64'(d3_out_data), 64'hA2);
    d3_flush = 1'b1;
    cycle();
    d3_flush = 1'b0;
    check("t6_flush_valid", 64'(d3_out_valid), 64'd0);
    check("t6_err_survives", 64'(d3_sel_err), 64'(exp_err));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6_err_reset", 64'(d3_sel_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
